// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared definitions for the 9-bit RISC core.
//            Holds the opcode encodings used for control-flow resolution
//            and the state encoding of the PC sequencer FSM.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int C_OPCODE_W = 6;

  // Control-flow opcodes; anything not listed is sequential
  localparam logic [C_OPCODE_W-1:0] OP_BEQ   = 6'b001111;
  localparam logic [C_OPCODE_W-1:0] OP_BNEQ  = 6'b010000;
  localparam logic [C_OPCODE_W-1:0] OP_BLZ   = 6'b010001;
  localparam logic [C_OPCODE_W-1:0] OP_JMP   = 6'b001101;
  localparam logic [C_OPCODE_W-1:0] OP_JMPR  = 6'b001110;
  localparam logic [C_OPCODE_W-1:0] OP_JAL   = 6'b011010;
  localparam logic [C_OPCODE_W-1:0] OP_BEQI  = 6'b011011;
  localparam logic [C_OPCODE_W-1:0] OP_BNEQI = 6'b011100;
  localparam logic [C_OPCODE_W-1:0] OP_BLT   = 6'b101000;
  localparam logic [C_OPCODE_W-1:0] OP_BGRT  = 6'b101001;
  localparam logic [C_OPCODE_W-1:0] OP_BLTI  = 6'b101010;
  localparam logic [C_OPCODE_W-1:0] OP_BGRTI = 6'b101011;
  localparam logic [C_OPCODE_W-1:0] OP_HALT  = 6'b111111;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_UPDATE = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/next_pc_calc.sv
`default_nettype none
// ============================================================================
// Module   : next_pc_calc
// Purpose  : Combinational next-PC and branch-taken resolution.
//            Compare-style branches (beq/beqi/blt/bgrt/blti/bgrti) rely on the
//            ALU having already folded the comparison into the zero flag.
// Ports    : opcode     in  OP_W  instruction opcode
//            zero_q     in  1     zero flag captured in EXEC
//            neg_q      in  1     negative flag captured in EXEC
//            pc         in  PC_W  current PC
//            endereco   in  PC_W  relative offset / absolute target
//            reg_target in  PC_W  register-sourced target (jmpr)
//            next_pc    out PC_W  resolved next PC (mod 2^PC_W)
//            taken      out 1     PC redirected away from pc+1
// Revision : 1.0 - initial release
// ============================================================================
module next_pc_calc
  import cpu_pkg::*;
#(
  parameter int PC_W = 9,
  parameter int OP_W = 6
) (
  input  logic [OP_W-1:0] opcode,
  input  logic            zero_q,
  input  logic            neg_q,
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] endereco,
  input  logic [PC_W-1:0] reg_target,
  output logic [PC_W-1:0] next_pc,
  output logic            taken
);

  localparam logic [PC_W-1:0] C_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  logic [PC_W-1:0] w_seq_pc;
  logic [PC_W-1:0] w_rel_pc;

  // Both additions wrap silently at 2^PC_W
  assign w_seq_pc = pc + C_ONE;
  assign w_rel_pc = pc + endereco;

  always_comb begin
    next_pc = w_seq_pc;
    taken   = 1'b0;
    case (opcode)
      OP_BEQ, OP_BEQI, OP_BLT, OP_BGRT, OP_BLTI, OP_BGRTI: begin
        if (zero_q) begin
          next_pc = w_rel_pc;
          taken   = 1'b1;
        end
      end
      OP_BNEQ, OP_BNEQI: begin
        if (!zero_q) begin
          next_pc = w_rel_pc;
          taken   = 1'b1;
        end
      end
      OP_BLZ: begin
        if (neg_q) begin
          next_pc = w_rel_pc;
          taken   = 1'b1;
        end
      end
      OP_JMP, OP_JAL: begin
        next_pc = endereco;
        taken   = 1'b1;
      end
      OP_JMPR: begin
        next_pc = reg_target;
        taken   = 1'b1;
      end
      OP_HALT: begin
        // PC freezes on the HALT instruction itself
        next_pc = pc;
      end
      default: begin
      end
    endcase
  end

endmodule : next_pc_calc
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Multi-cycle program-counter sequencer. Steps each instruction
//            through FETCH/DECODE/EXEC/UPDATE, captures ALU flags at the end
//            of EXEC, and commits the next PC in UPDATE. Owns the PC register.
// Config   : define PC_LINK_EN to add the link-register ports (link_we,
//            link_addr) driven by jal. Without it jal acts as jmp.
// Ports    : clk        in  1     rising-edge clock
//            rst        in  1     synchronous active-high reset
//            run        in  1     start request (IDLE only)
//            stall      in  1     hold EXEC
//            opcode     in  OP_W  opcode, valid from DECODE onward
//            endereco   in  PC_W  branch offset / jump target
//            reg_target in  PC_W  jmpr target
//            zero       in  1     ALU zero flag
//            negativo   in  1     ALU negative flag
//            pc         out PC_W  current PC
//            fetch_en   out 1     instruction-memory read strobe
//            exec_en    out 1     datapath execute enable
//            taken      out 1     redirect pulse in UPDATE
//            halted     out 1     core stopped on HALT
//            link_we    out 1     (PC_LINK_EN) link write strobe
//            link_addr  out PC_W  (PC_LINK_EN) return address pc+1
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 9,
  parameter int              OP_W     = 6,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic            stall,
  input  logic [OP_W-1:0] opcode,
  input  logic [PC_W-1:0] endereco,
  input  logic [PC_W-1:0] reg_target,
  input  logic            zero,
  input  logic            negativo,
  output logic [PC_W-1:0] pc,
  output logic            fetch_en,
  output logic            exec_en,
  output logic            taken,
`ifdef PC_LINK_EN
  output logic            link_we,
  output logic [PC_W-1:0] link_addr,
`endif
  output logic            halted
);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic            r_zero;
  logic            r_neg;
  logic [PC_W-1:0] w_next_pc;
  logic            w_taken;
  logic            w_exec_done;

  // EXEC completes on the first cycle without stall; flags are captured there
  assign w_exec_done = (r_state == ST_EXEC) && !stall;

  next_pc_calc #(
    .PC_W (PC_W),
    .OP_W (OP_W)
  ) u_next_pc_calc (
    .opcode     (opcode),
    .zero_q     (r_zero),
    .neg_q      (r_neg),
    .pc         (r_pc),
    .endereco   (endereco),
    .reg_target (reg_target),
    .next_pc    (w_next_pc),
    .taken      (w_taken)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
      r_zero  <= 1'b0;
      r_neg   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_exec_done) begin
        r_zero <= zero;
        r_neg  <= negativo;
      end
      if (r_state == ST_UPDATE) begin
        r_pc <= w_next_pc;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (run) w_state_nxt = ST_FETCH;
      ST_FETCH:  w_state_nxt = ST_DECODE;
      ST_DECODE: w_state_nxt = ST_EXEC;
      ST_EXEC:   if (!stall) w_state_nxt = ST_UPDATE;
      ST_UPDATE: w_state_nxt = (opcode == OP_HALT) ? ST_HALT : ST_FETCH;
      ST_HALT:   w_state_nxt = ST_HALT;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  assign pc       = r_pc;
  assign fetch_en = (r_state == ST_FETCH);
  assign exec_en  = (r_state == ST_EXEC);
  assign taken    = (r_state == ST_UPDATE) && w_taken;
  assign halted   = (r_state == ST_HALT);

`ifdef PC_LINK_EN
  // Return address is only driven while the strobe is high, zero otherwise
  assign link_we   = (r_state == ST_UPDATE) && (opcode == OP_JAL);
  assign link_addr = link_we ? (r_pc + {{(PC_W-1){1'b0}}, 1'b1}) : '0;
`endif

endmodule : pc_sequencer
`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Multi-cycle program-counter sequencer for the 9-bit RISC core. It steps each instruction through FETCH/DECODE/EXEC/UPDATE and samples the ALU `zero`/`negativo` flags in EXEC. It resolves branches and jumps from the 6-bit opcode and commits the next PC. It sits between instruction memory addressing and the control unit, and owns the only architectural PC register.

## Interface
Parameters:
- `PC_W`, 9, PC and target width
- `OP_W`, 6, opcode width
- `RESET_PC`, 9'd0, PC value after reset

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `run`  in  1  start request, sampled only in IDLE
- `stall`  in  1  hold EXEC (e.g. multi-cycle ALU op)
- `opcode`  in  OP_W  decoded instruction opcode, valid from DECODE onward
- `endereco`  in  PC_W  immediate branch offset / absolute jump target
- `reg_target`  in  PC_W  register-sourced target for jmpr
- `zero`  in  1  ALU zero/compare-true flag
- `negativo`  in  1  ALU negative flag
- `pc`  out  PC_W  current PC (instruction memory address)
- `fetch_en`  out  1  instruction-memory read strobe
- `exec_en`  out  1  datapath execute enable
- `taken`  out  1  one-cycle pulse in UPDATE when PC is redirected
- `halted`  out  1  core stopped on HALT opcode
- `link_we`  out  1  (PC_LINK_EN only) link-register write strobe
- `link_addr`  out  PC_W  (PC_LINK_EN only) return address `pc+1`

## Operation
- States: IDLE, FETCH, DECODE, EXEC, UPDATE, HALT.
- IDLE → FETCH when `run`=1. Otherwise stay.
- FETCH → DECODE → EXEC, each unconditionally.
- EXEC → UPDATE when `stall`=0. Otherwise stay in EXEC with `exec_en` held high.
- UPDATE → FETCH. Exception: HALT opcode (6'b111111) goes UPDATE → HALT.
- HALT is left only by `rst`.
- Flags `zero`/`negativo` are registered on the EXEC cycle where `stall`=0. UPDATE uses the registered copies only.
- Next-PC rules, applied in UPDATE (all arithmetic mod 2^PC_W, wrap silently):
  - beq, beqi, blt, bgrt, blti, bgrti: taken if zero=1, next = pc + endereco
  - bneq, bneqi: taken if zero=0, next = pc + endereco
  - blz: taken if negativo=1, next = pc + endereco
  - jmp, jal: taken always, next = endereco
  - jmpr: taken always, next = reg_target
  - not taken, or any other opcode: next = pc + 1, `taken`=0
- HALT opcode: pc unchanged.
- Unknown opcodes are treated as sequential, with no error.

## Timing
- Reset values: `pc`=RESET_PC, state IDLE, all strobes 0, `halted`=0, `link_addr`=0.
- `fetch_en`=1 exactly during FETCH. `exec_en`=1 during all EXEC cycles.
- Unstalled instruction: 4 cycles, FETCH to the next FETCH.
- New `pc` is visible the cycle after UPDATE, which is the next FETCH.
- `taken` and `link_we` are combinational on the UPDATE state, 1 cycle wide.
- `halted` rises the cycle after UPDATE of a HALT opcode.
- `rst` asserted in any state returns to IDLE with reset values on the next edge. It overrides `stall` and `run`.
- `stall` is ignored outside EXEC. `run` is ignored outside IDLE.

## Configuration
- `PC_LINK_EN` defined:
  - `link_we`/`link_addr` ports exist.
  - For jal in UPDATE: `link_we`=1 and `link_addr`=pc+1 (mod 2^PC_W).
- `PC_LINK_EN` undefined:
  - Ports omitted.
  - jal behaves exactly as jmp.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode constants (beq 6'b001111, bneq 6'b010000, blz 6'b010001, jmp 6'b001101, jmpr 6'b001110, jal 6'b011010, beqi 6'b011011, bneqi 6'b011100, blt 6'b101000, bgrt 6'b101001, blti 6'b101010, bgrti 6'b101011, halt 6'b111111)
  - the state enum
- One sub-module, `next_pc_calc`: combinational next-PC/taken resolution from opcode, registered flags, pc, endereco, reg_target. The FSM and PC register stay in the top.

## Test plan
- Reset, `run`=1, opcode add (6'b000000) repeated → pc 0,1,2 at successive FETCHes spaced 4 cycles; `taken` never asserted.
- pc=5, beq, endereco=3, zero=1 → pc=8, `taken` pulse in UPDATE. Repeat with zero=0 → pc=6, no pulse.
- pc=510, bneq, endereco=4, zero=0 → pc wraps to 2.
- `stall` high 3 cycles in EXEC with jmpr, reg_target=9'h1A0 → instruction takes 7 cycles, then pc=0x1A0. Flags changed during the stall and after the stall releases have no effect.
- jal endereco=40 at pc=12 with PC_LINK_EN → `link_we` pulse, `link_addr`=13, pc=40. Without the macro → pc=40, no link ports.
- HALT opcode → `halted`=1, pc frozen for 20 cycles. `rst` mid-EXEC of a branch → IDLE, pc=RESET_PC, no `taken` pulse.
